// File: rtl/circuito_exp4.sv
// circuito_exp4 - top level of a single-player "Genius" memory-sequence game.
//
// The player reproduces a fixed 16-step sequence of one-hot plays on the
// switches. A control FSM sequences a small datapath made of a step counter,
// the sequence ROM, a play register, an equality comparator and a rising-edge
// detector on the OR of the switches.
//
// Ports:
//   clock          in   system clock, rising edge active
//   reset          in   asynchronous reset, active low
//   iniciar        in   start/restart request (level sampled)
//   chaves [3:0]   in   player switches (one-hot play)
//   acertou        out  whole sequence reproduced correctly
//   errou          out  wrong play entered
//   pronto         out  game finished (either end state)
//   leds [3:0]     out  copy of chaves
//   db_igual       out  play register equals ROM output
//   db_contagem    out  7-seg (gfedcba, active low) of step counter
//   db_memoria     out  7-seg of ROM output
//   db_estado      out  7-seg of FSM state code
//   db_jogadafeita out  7-seg of play register
//   db_clock       out  copy of clock
//   db_tem_jogada  out  one-cycle pulse when a new play starts
module circuito_exp4 (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic       db_clock,
  output logic       db_tem_jogada
);

  // State encodings double as the digit shown on db_estado.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_ERROU   = 4'hE
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  contagem_reg;
  logic [3:0]  jogada_reg;
  logic        or_reg;

  logic        zera_c, conta_c, zera_r, registra_r;
  logic        fim_c, igual, tem_jogada, or_chaves;
  logic [3:0]  memoria;

  // Fixed game sequence, read combinationally from the step counter.
  function automatic logic [3:0] rom_lookup(input logic [3:0] addr);
    case (addr)
      4'd0:  rom_lookup = 4'b0001;
      4'd1:  rom_lookup = 4'b0010;
      4'd2:  rom_lookup = 4'b0100;
      4'd3:  rom_lookup = 4'b1000;
      4'd4:  rom_lookup = 4'b0100;
      4'd5:  rom_lookup = 4'b0010;
      4'd6:  rom_lookup = 4'b0001;
      4'd7:  rom_lookup = 4'b0001;
      4'd8:  rom_lookup = 4'b0010;
      4'd9:  rom_lookup = 4'b0010;
      4'd10: rom_lookup = 4'b0100;
      4'd11: rom_lookup = 4'b0100;
      4'd12: rom_lookup = 4'b1000;
      4'd13: rom_lookup = 4'b1000;
      4'd14: rom_lookup = 4'b0001;
      default: rom_lookup = 4'b0100;
    endcase
  endfunction

  // Hex digit to 7-segment, segment order gfedcba, active low.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // ---------------- datapath ----------------
  assign memoria    = rom_lookup(contagem_reg);
  assign fim_c      = (contagem_reg == 4'd15);
  assign igual      = (jogada_reg == memoria);
  assign or_chaves  = |chaves;
  // Pulse only on the 0->1 edge of "any switch on"; holding switches keeps
  // or_reg high so no repeat pulses, and returning to 0000 re-arms it.
  assign tem_jogada = or_chaves & ~or_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem_reg <= 4'd0;
      jogada_reg   <= 4'd0;
      or_reg       <= 1'b0;
    end else begin
      or_reg <= or_chaves;
      if (zera_c)
        contagem_reg <= 4'd0;
      else if (conta_c)
        contagem_reg <= contagem_reg + 4'd1;
      if (zera_r)
        jogada_reg <= 4'd0;
      else if (registra_r)
        jogada_reg <= chaves;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state_reg <= INICIAL;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    zera_c     = 1'b0;
    zera_r     = 1'b0;
    conta_c    = 1'b0;
    registra_r = 1'b0;
    case (state_reg)
      INICIAL:    if (iniciar) state_next = PREPARACAO;
      PREPARACAO: begin
        zera_c     = 1'b1;
        zera_r     = 1'b1;
        state_next = ESPERA;
      end
      ESPERA:     if (tem_jogada) state_next = REGISTRA;
      REGISTRA: begin
        registra_r = 1'b1;
        state_next = COMPARACAO;
      end
      // A wrong play wins over end-of-sequence.
      COMPARACAO: begin
        if (!igual)     state_next = FIM_ERROU;
        else if (fim_c) state_next = FIM_ACERTOU;
        else            state_next = PROXIMO;
      end
      PROXIMO: begin
        conta_c    = 1'b1;
        state_next = ESPERA;
      end
      FIM_ACERTOU, FIM_ERROU: if (iniciar) state_next = PREPARACAO;
      default:    state_next = INICIAL;
    endcase
  end

  assign acertou = (state_reg == FIM_ACERTOU);
  assign errou   = (state_reg == FIM_ERROU);
  assign pronto  = acertou | errou;

  // ---------------- debug / board outputs ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_leds
      assign leds[gi] = chaves[gi];
    end
  endgenerate

  assign db_clock       = clock;
  assign db_tem_jogada  = tem_jogada;
  assign db_igual       = igual;
  assign db_contagem    = hex7(contagem_reg);
  assign db_memoria     = hex7(memoria);
  assign db_estado      = hex7(state_reg);
  assign db_jogadafeita = hex7(jogada_reg);

endmodule

// File: tb/tb_circuito_exp4.sv
// tb_circuito_exp4 - self-checking bench for circuito_exp4.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Each play pushes its expected outcome to a scoreboard queue,
// which is popped when the DUT reaches the comparison/judgement states.
module tb_circuito_exp4;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic       acertou, errou, pronto, db_igual, db_clock, db_tem_jogada;
  logic [3:0] leds;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;

  circuito_exp4 dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .chaves         (chaves),
    .acertou        (acertou),
    .errou          (errou),
    .pronto         (pronto),
    .leds           (leds),
    .db_igual       (db_igual),
    .db_contagem    (db_contagem),
    .db_memoria     (db_memoria),
    .db_estado      (db_estado),
    .db_jogadafeita (db_jogadafeita),
    .db_clock       (db_clock),
    .db_tem_jogada  (db_tem_jogada)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // 7-seg reference (gfedcba, active low) and the game sequence.
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [3:0] ROM_M [16] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};

  typedef struct {
    string      tag;
    logic [6:0] igual;
    logic [6:0] estado;
    logic [6:0] cont;
    logic       adv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulse_cnt = 0;
  int   step_m = 0;

  always @(negedge clock) if (db_tem_jogada === 1'b1) pulse_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic a, input logic e, input logic p);
    chk({tag, "_acertou"}, {6'b0, acertou}, {6'b0, a});
    chk({tag, "_errou"},   {6'b0, errou},   {6'b0, e});
    chk({tag, "_pronto"},  {6'b0, pronto},  {6'b0, p});
  endtask

  // Request a (re)start and expect the game waiting for the first play.
  task automatic start_game(input string tag);
    @(posedge clock); #1 iniciar = 1'b1;
    repeat (5) @(posedge clock);
    #1 iniciar = 1'b0;
    step_m = 0;
    @(negedge clock);
    chk({tag, "_estado"}, db_estado, SEG[2]);
    chk({tag, "_contagem"}, db_contagem, SEG[0]);
    chk({tag, "_memoria"}, db_memoria, SEG[1]);
    chk_flags(tag, 1'b0, 1'b0, 1'b0);
    $display("start %s estado=%b contagem=%b", tag, db_estado, db_contagem);
  endtask

  // One play: drive v for 'hold' clocks, then 0000 for 'idle' clocks.
  task automatic do_play(input logic [3:0] v, input int hold, input int idle, input string tag);
    exp_t e, got;
    logic ok;
    int   p0, used;
    ok       = (v == ROM_M[step_m]);
    e.tag    = tag;
    e.igual  = {6'b0, ok};
    e.adv    = ok && (step_m != 15);
    e.estado = !ok ? SEG[14] : ((step_m == 15) ? SEG[10] : SEG[6]);
    e.cont   = SEG[(step_m + 1) % 16];
    p0 = pulse_cnt;
    @(posedge clock); #1 chaves = v;
    sb.push_back(e);
    if (e.adv) step_m++;
    @(negedge clock);
    chk({tag, "_leds"}, {3'b0, leds}, {3'b0, v});
    repeat (2) @(negedge clock);              // now in COMPARACAO
    got = sb.pop_front();
    chk({got.tag, "_igual"}, {6'b0, db_igual}, got.igual);
    @(negedge clock);                          // judged
    chk({got.tag, "_estado"}, db_estado, got.estado);
    used = 3;
    if (got.adv) begin
      @(negedge clock);                        // counter advanced, back in ESPERA
      chk({got.tag, "_contagem"}, db_contagem, got.cont);
      chk({got.tag, "_espera"}, db_estado, SEG[2]);
      used = 4;
    end
    repeat (hold - used) @(posedge clock);
    @(posedge clock); #1 chaves = 4'b0000;
    repeat (idle) @(posedge clock);
    @(negedge clock);
    chk({tag, "_pulses"}, 7'(pulse_cnt - p0), 7'd1);
    $display("play %s chaves=%b igual=%b estado=%b contagem=%b", tag, v, db_igual, db_estado, db_contagem);
  endtask

  initial begin
    reset   = 1'b1;
    iniciar = 1'b0;
    chaves  = 4'b0000;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("rst_estado", db_estado, SEG[0]);
    chk("rst_contagem", db_contagem, SEG[0]);
    chk("rst_jogada", db_jogadafeita, SEG[0]);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    $display("reset estado=%b contagem=%b", db_estado, db_contagem);

    // Game 1: three correct plays then a wrong one.
    start_game("g1");
    do_play(4'b0001, 10, 10, "g1p0");
    do_play(4'b0010, 10, 10, "g1p1");
    do_play(4'b0100, 10, 10, "g1p2");
    do_play(4'b0001, 5, 5, "g1p3_wrong");
    chk("g1_hold_estado", db_estado, SEG[14]);
    chk_flags("g1_end", 1'b0, 1'b1, 1'b1);

    // Game 2: full correct sequence.
    start_game("g2");
    for (int i = 0; i < 16; i++)
      do_play(ROM_M[i], 5, 2, $sformatf("g2p%0d", i));
    chk("g2_estado", db_estado, SEG[10]);
    chk("g2_contagem", db_contagem, SEG[15]);
    chk_flags("g2_end", 1'b1, 1'b0, 1'b1);

    // Game 3: multi-hot play is judged wrong.
    start_game("g3");
    do_play(4'b0001, 5, 2, "g3p0");
    do_play(4'b0011, 5, 2, "g3p1_multihot");
    chk_flags("g3_end", 1'b0, 1'b1, 1'b1);

    // Game 4: reset in the middle of a game.
    start_game("g4");
    do_play(4'b0001, 5, 2, "g4p0");
    do_play(4'b0010, 5, 2, "g4p1");
    @(posedge clock); #1 reset = 1'b0;
    #1;
    chk("midrst_estado", db_estado, SEG[0]);
    chk("midrst_contagem", db_contagem, SEG[0]);
    chk("midrst_jogada", db_jogadafeita, SEG[0]);
    chk_flags("midrst", 1'b0, 1'b0, 1'b0);
    $display("midreset estado=%b contagem=%b", db_estado, db_contagem);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("postrst_estado", db_estado, SEG[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/circuito_exp4.md
Name: circuito_exp4

Overview:
- Top level of a single-player memory-sequence game ("Genius" style) on the lab board.
- Player must reproduce a fixed 16-step sequence of one-hot 4-bit values on `chaves`, one play at a time.
- Contains a control FSM and a datapath: step counter, sequence ROM, play register, comparator and switch-edge detector.
- Provides 7-segment debug displays for bring-up.

Parameters:
- None; all widths are fixed.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 forces the initial state.
- iniciar  in  1  start/restart request; level-sampled.
- chaves  in  4  player switches; one-hot play value.
- acertou  out  1  high in FIM_ACERTOU (whole sequence correct).
- errou  out  1  high in FIM_ERROU (wrong play).
- pronto  out  1  high in either end state.
- leds  out  4  direct copy of chaves.
- db_igual  out  1  comparator result: play register == ROM output.
- db_contagem  out  7  hex 7-seg of step counter.
- db_memoria  out  7  hex 7-seg of ROM output.
- db_estado  out  7  hex 7-seg of FSM state code.
- db_jogadafeita  out  7  hex 7-seg of play register.
- db_clock  out  1  copy of clock.
- db_tem_jogada  out  1  one-cycle pulse on a new play.

Behaviour:
- **7-seg encoding:** segments gfedcba, active-low. Hex 0..F decode: 0=1000000, 1=1111001, 2=0100100, 4=0011001, 5=0010010, 6=0000010, 8=0000000, A=0001000, E=0000110; remaining digits per standard hex.
- **Sequence ROM:** 16x4, combinational read, addressed by the 4-bit counter. Contents, addresses 0..15:
  - 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001,
  - 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- **Step counter:** 4-bit, synchronous clear (zeraC) and enable (contaC). fimC=1 when count==15.
- **Play register:** 4-bit, synchronous clear (zeraR) and load (registraR) of chaves.
- **Edge detector:**
  - Pulse source = OR of chaves, delayed by one flop.
  - tem_jogada=1 for exactly one cycle when the OR rises 0->1.
  - Holding the switches generates no further pulses; releasing to 0000 re-arms the detector.
- **FSM codes** (shown on db_estado):
  - INICIAL=0, PREPARACAO=1, ESPERA=2, REGISTRA=4, COMPARACAO=5, PROXIMO=6, FIM_ACERTOU=A, FIM_ERROU=E.
- **Transitions:**
  - INICIAL: iniciar=1 -> PREPARACAO; else stay.
  - PREPARACAO: assert zeraC and zeraR; next ESPERA unconditionally.
  - ESPERA: tem_jogada=1 -> REGISTRA; else stay.
  - REGISTRA: assert registraR; next COMPARACAO.
  - COMPARACAO (priority order):
    - igual=0 -> FIM_ERROU;
    - else fimC=1 -> FIM_ACERTOU;
    - else -> PROXIMO.
  - PROXIMO: assert contaC; next ESPERA.
  - FIM_ACERTOU / FIM_ERROU: hold outputs; iniciar=1 -> PREPARACAO; else stay.
- **Latency:** a play is judged 3 clocks after the edge-detect pulse (REGISTRA, then COMPARACAO, then the end/PROXIMO state).
- **Reset (reset=0, async):**
  - FSM -> INICIAL; counter=0; register=0; edge-detector flop=0.
  - acertou=errou=pronto=0.
  - Reset mid-game abandons the game.
- **Simultaneous events / boundary conditions:**
  - iniciar is ignored outside INICIAL and the end states.
  - Switch changes are ignored outside ESPERA, apart from edge-detector tracking.
  - A multi-hot play compares unequal and yields FIM_ERROU.
  - Counter never wraps during play; reaching 15 with a correct play ends the game.
- leds and db_clock are purely combinational copies.

Test Plan:
- Reset, then 10 idle clocks -> db_estado=0 (1000000); acertou=errou=pronto=0; db_contagem shows 0.
- iniciar=1 for 5 clocks -> PREPARACAO then ESPERA (db_estado shows 2); counter=0; db_memoria shows 1.
- Plays 0001, 0010, 0100, each held 10 clocks with 10 idle clocks between:
  - each play gives one db_tem_jogada pulse and db_igual=1;
  - counter advances to 1, 2, 3;
  - no extra pulses while a switch is held.
- 4th play 0001 (expected 1000), held 5 clocks -> FIM_ERROU: errou=1, pronto=1, acertou=0, db_estado shows E; state holds after switches return to 0000.
- iniciar=1 from FIM_ERROU -> PREPARACAO then ESPERA; counter=0; errou=pronto=0.
- Full correct 16-play sequence -> FIM_ACERTOU (db_estado shows A, acertou=1, pronto=1, counter=15).
- reset=0 asserted mid-game -> immediate return to INICIAL with all outputs cleared.
